// File: rtl/uart_tx_arbiter_if.sv
// Bundles both byte clients and the shared transmitter handshake.
// The arbiter is the slave; the client/transmitter side is the master.
interface uart_tx_arbiter_if;
    logic       REQ0;
    logic [7:0] DATA0;
    logic       ACK0;
    logic       REQ1;
    logic [7:0] DATA1;
    logic       ACK1;
    logic       TX_REQ;
    logic [7:0] TX_DATA;
    logic       TX_ACK;
    logic       TX_SRC;
    logic       BUSY;
    logic       ERR;
    logic [7:0] CNT0;
    logic [7:0] CNT1;

    modport slave (
        input  REQ0, DATA0, REQ1, DATA1, TX_ACK,
        output ACK0, ACK1, TX_REQ, TX_DATA, TX_SRC, BUSY, ERR, CNT0, CNT1
    );

    modport master (
        output REQ0, DATA0, REQ1, DATA1, TX_ACK,
        input  ACK0, ACK1, TX_REQ, TX_DATA, TX_SRC, BUSY, ERR, CNT0, CNT1
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one four-phase REQ/ACK UART transmitter
// between two byte clients, with a watchdog on the transmitter ack.
module uart_tx_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd5000
) (
    input  logic             clk,
    input  logic             clr,
    uart_tx_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a client request
    // TXH   | TX_REQ high, waiting for TX_ACK=1 (watchdog running)
    // TXL   | TX_REQ low, waiting for TX_ACK=0
    // CACK  | client ACK high, waiting for client REQ=0
    typedef enum logic [1:0] {IDLE, TXH, TXL, CACK} state_e;

    state_e      state_q, state_d;
    logic        gnt_src;
    logic        ptr_q, ptr_d;
    logic        tx_req_q, tx_req_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_src_q, tx_src_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [7:0]  cnt0_q, cnt0_d;
    logic [7:0]  cnt1_q, cnt1_d;
    logic [15:0] wd_q, wd_d;
    logic        req_src;
    logic        wd_hit;

    assign req_src = tx_src_q ? bus.REQ1 : bus.REQ0;
    assign wd_hit  = (TIMEOUT != 16'd0) && (wd_q == TIMEOUT - 16'd1);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b1;
            tx_req_q  <= 1'b0;
            tx_data_q <= 8'd0;
            tx_src_q  <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt0_q    <= 8'd0;
            cnt1_q    <= 8'd0;
            wd_q      <= 16'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            tx_req_q  <= tx_req_d;
            tx_data_q <= tx_data_d;
            tx_src_q  <= tx_src_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            wd_q      <= wd_d;
        end
    end

    // On a tie the client that was not served last wins.
    always_comb begin
        state_d = state_q;
        gnt_src = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.REQ0 && (!bus.REQ1 || ptr_q)) begin
                    gnt_src = 1'b0;
                    state_d = TXH;
                end else if (bus.REQ1) begin
                    gnt_src = 1'b1;
                    state_d = TXH;
                end
            end
            TXH: begin
                if (bus.TX_ACK)  state_d = TXL;
                else if (wd_hit) state_d = CACK;
            end
            TXL:     if (!bus.TX_ACK) state_d = CACK;
            CACK:    if (!req_src)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        tx_req_d  = tx_req_q;
        tx_data_d = tx_data_q;
        tx_src_d  = tx_src_q;
        ack0_d    = ack0_q;
        ack1_d    = ack1_q;
        err_d     = err_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        wd_d      = wd_q;
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (state_d == TXH) begin
                    tx_req_d  = 1'b1;
                    tx_src_d  = gnt_src;
                    tx_data_d = gnt_src ? bus.DATA1 : bus.DATA0;
                    wd_d      = 16'd0;
                end
            end
            TXH: begin
                if (state_d == TXL) begin
                    tx_req_d = 1'b0;
                end else if (state_d == CACK) begin
                    // Watchdog abort: release the client as if the byte had gone out.
                    tx_req_d = 1'b0;
                    err_d    = 1'b1;
                    ack0_d   = ~tx_src_q;
                    ack1_d   = tx_src_q;
                end else if (wd_q != 16'hFFFF) begin
                    wd_d = wd_q + 16'd1;
                end
            end
            TXL: begin
                if (state_d == CACK) begin
                    ack0_d = ~tx_src_q;
                    ack1_d = tx_src_q;
                end
            end
            CACK: begin
                if (state_d == IDLE) begin
                    ack0_d = 1'b0;
                    ack1_d = 1'b0;
                    ptr_d  = tx_src_q;
                    if (tx_src_q) cnt1_d = cnt1_q + 8'd1;
                    else          cnt0_d = cnt0_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.ACK0    = ack0_q;
    assign bus.ACK1    = ack1_q;
    assign bus.TX_REQ  = tx_req_q;
    assign bus.TX_DATA = tx_data_q;
    assign bus.TX_SRC  = tx_src_q;
    assign bus.BUSY    = busy_q;
    assign bus.ERR     = err_q;
    assign bus.CNT0    = cnt0_q;
    assign bus.CNT1    = cnt1_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single byte, ties, fairness,
// watchdog abort, async reset mid-transfer and data-capture stability.
module tb_uart_tx_arbiter;
    logic clk;
    logic clr;
    int   checks;
    int   failures;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.TIMEOUT(16'd8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.REQ0   = 1'b0;
        bus.REQ1   = 1'b0;
        bus.TX_ACK = 1'b0;
        clr = 1'b0;
        tick();
        tick();
        clr = 1'b1;
    endtask

    // One full zero-latency transfer; the grant is expected on the first edge.
    task automatic serve(input bit src, input logic [7:0] data, input bit rehold);
        tick();
        chk("grant_txreq", {15'd0, bus.TX_REQ}, 16'd1);
        chk("grant_src", {15'd0, bus.TX_SRC}, {15'd0, src});
        chk("grant_data", {8'd0, bus.TX_DATA}, {8'd0, data});
        bus.TX_ACK = 1'b1;
        tick();
        chk("txack_drop", {15'd0, bus.TX_REQ}, 16'd0);
        chk("txl_noack", {14'd0, bus.ACK1, bus.ACK0}, 16'd0);
        bus.TX_ACK = 1'b0;
        tick();
        chk("cack_ack", {14'd0, bus.ACK1, bus.ACK0}, src ? 16'd2 : 16'd1);
        if (src) bus.REQ1 = 1'b0;
        else     bus.REQ0 = 1'b0;
        tick();
        chk("done_ack", {14'd0, bus.ACK1, bus.ACK0}, 16'd0);
        chk("done_busy", {15'd0, bus.BUSY}, 16'd0);
        if (rehold) begin
            if (src) bus.REQ1 = 1'b1;
            else     bus.REQ0 = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (clr) begin
            checks++;
            assert (!(bus.ACK0 && bus.ACK1)) else begin
                failures++;
                $error("FAIL ack_excl observed=%0b%0b expected=not_both", bus.ACK0, bus.ACK1);
            end
            checks++;
            assert (!(bus.TX_REQ && (bus.ACK0 || bus.ACK1))) else begin
                failures++;
                $error("FAIL txreq_ack_excl observed=%0b/%0b%0b expected=not_together",
                       bus.TX_REQ, bus.ACK0, bus.ACK1);
            end
        end
    end

    initial begin
        checks     = 0;
        failures   = 0;
        bus.REQ0   = 1'b0;
        bus.REQ1   = 1'b0;
        bus.DATA0  = 8'h00;
        bus.DATA1  = 8'h00;
        bus.TX_ACK = 1'b0;
        clr = 1'b1;
        #1 clr = 1'b0;
        #1;
        chk("rst_txreq", {15'd0, bus.TX_REQ}, 16'd0);
        chk("rst_acks", {14'd0, bus.ACK1, bus.ACK0}, 16'd0);
        chk("rst_busy", {15'd0, bus.BUSY}, 16'd0);
        chk("rst_err", {15'd0, bus.ERR}, 16'd0);
        chk("rst_data", {8'd0, bus.TX_DATA}, 16'd0);
        chk("rst_src", {15'd0, bus.TX_SRC}, 16'd0);
        chk("rst_cnts", {bus.CNT1, bus.CNT0}, 16'd0);
        tick();
        clr = 1'b1;

        // TX_ACK in IDLE must be ignored
        bus.TX_ACK = 1'b1;
        tick();
        chk("idle_txack_busy", {15'd0, bus.BUSY}, 16'd0);
        chk("idle_txack_req", {15'd0, bus.TX_REQ}, 16'd0);
        bus.TX_ACK = 1'b0;
        tick();

        // single byte, transmitter acks after 3 cycles and releases after 2
        bus.REQ0  = 1'b1;
        bus.DATA0 = 8'hA5;
        tick();
        chk("s_req", {15'd0, bus.TX_REQ}, 16'd1);
        chk("s_data", {8'd0, bus.TX_DATA}, 16'h00A5);
        chk("s_src", {15'd0, bus.TX_SRC}, 16'd0);
        chk("s_busy", {15'd0, bus.BUSY}, 16'd1);
        tick();
        tick();
        chk("s_req_hold", {15'd0, bus.TX_REQ}, 16'd1);
        bus.TX_ACK = 1'b1;
        tick();
        chk("s_req_drop", {15'd0, bus.TX_REQ}, 16'd0);
        tick();
        chk("s_ack0_wait", {15'd0, bus.ACK0}, 16'd0);
        bus.TX_ACK = 1'b0;
        tick();
        chk("s_ack0_rise", {15'd0, bus.ACK0}, 16'd1);
        bus.REQ0 = 1'b0;
        tick();
        chk("s_ack0_fall", {15'd0, bus.ACK0}, 16'd0);
        chk("s_cnt0", {8'd0, bus.CNT0}, 16'd1);
        chk("s_err", {15'd0, bus.ERR}, 16'd0);

        // simultaneous requests after reset
        do_reset();
        bus.DATA0 = 8'h11;
        bus.DATA1 = 8'h22;
        bus.REQ0  = 1'b1;
        bus.REQ1  = 1'b1;
        serve(1'b0, 8'h11, 1'b0);
        serve(1'b1, 8'h22, 1'b0);
        chk("sim_cnts", {bus.CNT1, bus.CNT0}, 16'h0101);

        // fairness with both clients continuously requesting
        do_reset();
        bus.DATA0 = 8'h30;
        bus.DATA1 = 8'h31;
        bus.REQ0  = 1'b1;
        bus.REQ1  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            serve(i[0], i[0] ? 8'h31 : 8'h30, i < 4);
        end
        chk("fair_cnts", {bus.CNT1, bus.CNT0}, 16'h0303);

        // watchdog with silent transmitter
        do_reset();
        bus.DATA0 = 8'h5A;
        bus.REQ0  = 1'b1;
        tick();
        chk("wd_req_start", {15'd0, bus.TX_REQ}, 16'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("wd_req_held", {15'd0, bus.TX_REQ}, 16'd1);
        end
        tick();
        chk("wd_req_drop", {15'd0, bus.TX_REQ}, 16'd0);
        chk("wd_err", {15'd0, bus.ERR}, 16'd1);
        chk("wd_ack0", {15'd0, bus.ACK0}, 16'd1);
        bus.REQ0 = 1'b0;
        tick();
        chk("wd_ack0_fall", {15'd0, bus.ACK0}, 16'd0);
        chk("wd_cnt0", {8'd0, bus.CNT0}, 16'd1);
        bus.DATA0 = 8'h77;
        bus.REQ0  = 1'b1;
        serve(1'b0, 8'h77, 1'b0);
        chk("wd_cnt0_after", {8'd0, bus.CNT0}, 16'd2);
        chk("wd_err_sticky", {15'd0, bus.ERR}, 16'd1);

        // async reset while in TXL
        bus.DATA1 = 8'h99;
        bus.REQ1  = 1'b1;
        tick();
        chk("rm_grant1", {15'd0, bus.TX_SRC}, 16'd1);
        bus.TX_ACK = 1'b1;
        tick();
        chk("rm_in_txl_busy", {15'd0, bus.BUSY}, 16'd1);
        #2;
        clr = 1'b0;
        #1;
        chk("rm_txreq", {15'd0, bus.TX_REQ}, 16'd0);
        chk("rm_acks", {14'd0, bus.ACK1, bus.ACK0}, 16'd0);
        chk("rm_busy", {15'd0, bus.BUSY}, 16'd0);
        chk("rm_err", {15'd0, bus.ERR}, 16'd0);
        chk("rm_cnts", {bus.CNT1, bus.CNT0}, 16'd0);
        chk("rm_data", {8'd0, bus.TX_DATA}, 16'd0);
        bus.TX_ACK = 1'b0;
        bus.DATA0  = 8'hC3;
        bus.REQ0   = 1'b1;
        tick();
        clr = 1'b1;
        serve(1'b0, 8'hC3, 1'b0);
        serve(1'b1, 8'h99, 1'b0);
        chk("rm_cnts_after", {bus.CNT1, bus.CNT0}, 16'h0101);

        // DATA0 changes one cycle after grant
        bus.DATA0 = 8'h3C;
        bus.REQ0  = 1'b1;
        tick();
        chk("ds_grant", {8'd0, bus.TX_DATA}, 16'h003C);
        bus.DATA0 = 8'hFF;
        tick();
        chk("ds_txh", {8'd0, bus.TX_DATA}, 16'h003C);
        bus.TX_ACK = 1'b1;
        tick();
        chk("ds_txl", {8'd0, bus.TX_DATA}, 16'h003C);
        bus.TX_ACK = 1'b0;
        tick();
        chk("ds_cack", {8'd0, bus.TX_DATA}, 16'h003C);
        chk("ds_ack0", {15'd0, bus.ACK0}, 16'd1);
        bus.REQ0 = 1'b0;
        tick();
        chk("ds_done", {8'd0, bus.TX_DATA}, 16'h003C);
        chk("ds_cnt0", {8'd0, bus.CNT0}, 16'd2);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between two byte sources using the four-phase REQ/ACK handshake that the UART blocks already use. Each client presents a byte with a request. The arbiter grants round-robin, latches the byte and runs the transmitter handshake to completion. It then acknowledges the client. A watchdog keeps a silent transmitter from hanging either client.

## Interface
- TIMEOUT, default 16'd5000: max cycles to wait for TX_ACK rise after TX_REQ rises; 0 disables the watchdog.
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- REQ0  in  1  client 0 request; DATA0 stable while high.
- DATA0  in  8  client 0 byte.
- ACK0  out  1  client 0 acknowledge.
- REQ1  in  1  client 1 request.
- DATA1  in  8  client 1 byte.
- ACK1  out  1  client 1 acknowledge.
- TX_REQ  out  1  request to transmitter.
- TX_DATA  out  8  byte to transmitter; stable while TX_REQ high.
- TX_ACK  in  1  transmitter acknowledge.
- TX_SRC  out  1  client currently or last granted.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  1  sticky; set on watchdog expiry; cleared only by reset.
- CNT0, CNT1  out  8  bytes completed per client; wrap 255->0; aborted bytes also counted.

## Operation
- All outputs are registered. Reset values: ACK0=ACK1=TX_REQ=BUSY=ERR=0, TX_DATA=0, TX_SRC=0, CNT0=CNT1=0, state IDLE, last-served pointer=1 (client 0 wins the first tie).
- States: IDLE, TXH (TX_REQ high, wait TX_ACK=1), TXL (TX_REQ low, wait TX_ACK=0), CACK (client ACK high, wait client REQ=0).
- IDLE:
  - Only REQ0 high: grant 0.
  - Only REQ1 high: grant 1.
  - Both high: grant the client that is not the last-served pointer.
  - On grant: latch TX_DATA from the chosen DATAn, set TX_SRC, TX_REQ=1, clear the watchdog counter, go to TXH.
- TXH:
  - TX_ACK=1: TX_REQ=0, go to TXL.
  - Otherwise, if TIMEOUT!=0 and counter==TIMEOUT-1: TX_REQ=0, ERR=1, go to CACK with ACK[TX_SRC]=1.
  - Otherwise counter+1 (16-bit, saturating).
- TXL: TX_ACK=0 -> ACK[TX_SRC]=1, go to CACK.
- CACK:
  - Client REQ[TX_SRC]=0: ACK=0, CNT[TX_SRC]+1, pointer=TX_SRC, go to IDLE.
  - If REQ is already low on entry, ACK stays high exactly one cycle.
- DATAn is sampled only at grant. Later changes to DATAn do not affect TX_DATA.
- A request from the non-granted client is held pending and is never lost. That client is served next because the pointer update guarantees it.
- TX_ACK high while in IDLE, TXL-entry or CACK is ignored. Only the level in TXH/TXL matters.
- Reset asserted mid-transfer: all outputs drop asynchronously to their reset values. There is no completion and no count.

## Timing
- Grant latency: REQn sampled high in IDLE at edge k -> TX_REQ=1, TX_DATA valid after edge k.
- TX_ACK rise sampled at edge m -> TX_REQ=0 after m.
- TX_ACK fall sampled at edge p -> ACKn=1 after p.
- REQn fall sampled at edge q -> ACKn=0, BUSY=0 after q. A pending request can be granted at edge q+1.
- Minimum transfer with zero-latency peers: 4 cycles between grants.
- Watchdog: TX_REQ is high exactly TIMEOUT cycles before the abort drops it.
- ACK0 and ACK1 are never high together. TX_REQ and ACKn are never high together.

## Test plan
- Single byte: REQ0=1 with DATA0=8'hA5; transmitter acks after 3 cycles and releases after 2 -> TX_DATA=8'hA5 and TX_SRC=0 while TX_REQ high; ACK0 rises only after TX_ACK falls; CNT0=1; ERR=0.
- Simultaneous after reset: REQ0 and REQ1 high in the same cycle with DATA0=8'h11 and DATA1=8'h22 -> 8'h11 is sent first, then 8'h22; CNT0=CNT1=1; ACK0 and ACK1 are never high together.
- Fairness: REQ0 and REQ1 held continuously for 6 transfers -> grant order 0,1,0,1,0,1; CNT0=CNT1=3.
- Watchdog: TIMEOUT=8 and TX_ACK held 0 -> TX_REQ is high exactly 8 cycles then drops; ERR=1; ACK0 pulses; CNT0=1. The next request is served normally and ERR stays 1.
- Reset mid-operation: clr driven low while in TXL -> TX_REQ, ACKn and BUSY go 0 immediately without a clock edge; counts are 0; the first transfer after reset grants client 0 on a tie.
- Data stability: DATA0 changes from 8'h3C to 8'hFF one cycle after grant -> TX_DATA stays 8'h3C until the transfer completes.
